ref_timeout_cnt: RTL and testbench

- Free-running DRAM refresh scheduler plus bus-cycle timeout counter in the FSB clock domain.
- Feeds the RAM controller (RefReq/RefUrgent, consumes RefAck) and the FSB ready/BERR logic (TimeoutA gates sound-RAM write ready; TimeoutB drives bus error for unclaimed cycles).
- Sits upstream of RAM and FSB; consumes CACT from the FSB cycle detector.

---
 rtl/mxse_pkg.sv | 24 ++
 rtl/ref_timeout_cnt_if.sv | 30 +++
 rtl/ref_sched.sv | 73 +++++++
 rtl/ref_timeout_cnt.sv | 52 +++++
 tb/tb_ref_timeout_cnt.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/mxse_pkg.sv
// Shared types and default timing constants for the FSB refresh/timeout block.
// Defaults assume a 25 MHz FSB clock: 16*24 clocks gives a ~15.4 us refresh interval.
package mxse_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PEND   = 2'd1,
      URGENT = 2'd2
   } refState_t;

   localparam int PRE_DIV   = 16;
   localparam int REF_TICKS = 24;
   localparam int TIMEOUT_A = 16;
   localparam int TIMEOUT_B = 255;

   // Bits needed to hold 0..maxVal, never less than one.
   function automatic int cntWidth(input int maxVal);
      int w;
      w = 1;
      while ((1 << w) <= maxVal) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/ref_timeout_cnt_if.sv
// Bundles the refresh handshake and bus-timeout signals between the FSB/RAM logic and the scheduler.
// master = the surrounding FSB/RAM side, slave = the scheduler itself.
interface ref_timeout_cnt_if;

   logic CACT;
   logic RefAck;
   logic RefReq;
   logic RefUrgent;
   logic TimeoutA;
   logic TimeoutB;

   modport master (
      output CACT,
      output RefAck,
      input  RefReq,
      input  RefUrgent,
      input  TimeoutA,
      input  TimeoutB
   );

   modport slave (
      input  CACT,
      input  RefAck,
      output RefReq,
      output RefUrgent,
      output TimeoutA,
      output TimeoutB
   );

endinterface

// File: rtl/ref_sched.sv
// Prescaler + interval counter + refresh request FSM; first request preDiv*refTicks clocks after reset.
// Request outputs decode the registered state, so they move on the edge that samples expire/RefAck.
module ref_sched
   import mxse_pkg::*;
#(
   parameter int preDiv   = PRE_DIV,
   parameter int refTicks = REF_TICKS
) (
   input  logic CLK_FSB,
   input  logic RES,
   input  logic refAck,
   output logic refReq,
   output logic refUrgent
);

   localparam int PW = cntWidth(preDiv - 1);
   localparam int IW = cntWidth(refTicks - 1);

   logic [PW-1:0] preCnt;
   logic [IW-1:0] intCnt;
   logic          tick;
   logic          expire;
   refState_t     state;
   refState_t     stateNext;

   assign tick   = (preCnt == PW'(preDiv - 1));
   assign expire = tick && (intCnt == IW'(refTicks - 1));

   always_ff @(posedge CLK_FSB) begin
      if (RES) begin
         preCnt <= '0;
         intCnt <= '0;
      end else begin
         preCnt <= tick ? '0 : preCnt + PW'(1);
         if (tick) begin
            intCnt <= (intCnt == IW'(refTicks - 1)) ? '0 : intCnt + IW'(1);
         end
      end
   end

   always_ff @(posedge CLK_FSB) begin
      if (RES) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // An ack coinciding with expire serves the old request and raises a fresh one.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (expire) stateNext = PEND;
         end
         PEND: begin
            if (refAck && !expire)      stateNext = IDLE;
            else if (expire && !refAck) stateNext = URGENT;
            else                        stateNext = PEND;
         end
         URGENT: begin
            if (refAck && !expire)     stateNext = IDLE;
            else if (refAck && expire) stateNext = PEND;
            else                       stateNext = URGENT;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign refReq    = (state == PEND) || (state == URGENT);
   assign refUrgent = (state == URGENT);

endmodule

// File: rtl/ref_timeout_cnt.sv
// DRAM refresh scheduler plus saturating bus-cycle timeout counter, all on CLK_FSB.
// Timeouts are registered: set on the edge whose incremented count hits the threshold, cleared by any CACT-low edge.
module ref_timeout_cnt
   import mxse_pkg::*;
#(
   parameter int preDiv   = PRE_DIV,
   parameter int refTicks = REF_TICKS,
   parameter int timeoutA = TIMEOUT_A,
   parameter int timeoutB = TIMEOUT_B
) (
   input  logic             CLK_FSB,
   input  logic             RES,
   ref_timeout_cnt_if.slave bus
);

   localparam int TW = cntWidth(timeoutB);

   logic [TW-1:0] toCnt;
   logic [TW-1:0] toCntInc;
   logic          toA;
   logic          toB;

   ref_sched #(
      .preDiv   (preDiv),
      .refTicks (refTicks)
   ) u_ref_sched (
      .CLK_FSB   (CLK_FSB),
      .RES       (RES),
      .refAck    (bus.RefAck),
      .refReq    (bus.RefReq),
      .refUrgent (bus.RefUrgent)
   );

   assign toCntInc = (toCnt == TW'(timeoutB)) ? toCnt : toCnt + TW'(1);

   // A single CACT-low sample between cycles is enough to restart the count.
   always_ff @(posedge CLK_FSB) begin
      if (RES || !bus.CACT) begin
         toCnt <= '0;
         toA   <= 1'b0;
         toB   <= 1'b0;
      end else begin
         toCnt <= toCntInc;
         if (toCntInc == TW'(timeoutA)) toA <= 1'b1;
         if (toCntInc == TW'(timeoutB)) toB <= 1'b1;
      end
   end

   assign bus.TimeoutA = toA;
   assign bus.TimeoutB = toB;

endmodule

// File: tb/tb_ref_timeout_cnt.sv
// Directed bench for ref_timeout_cnt: refresh interval timing, FSM coincidences, timeout thresholds, reset.
module tb_ref_timeout_cnt;

   logic clk = 1'b0;
   logic res;
   int   checks = 0;
   int   errors = 0;
   int   n = 0;

   ref_timeout_cnt_if bus();

   ref_timeout_cnt dut (
      .CLK_FSB (clk),
      .RES     (res),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      n = n + 1;
   endtask

   task automatic stepTo(input int target);
      while (n < target) step();
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag, input logic rr, input logic ru,
                           input logic ta, input logic tb);
      check({tag, ".RefReq"},    bus.RefReq,    rr);
      check({tag, ".RefUrgent"}, bus.RefUrgent, ru);
      check({tag, ".TimeoutA"},  bus.TimeoutA,  ta);
      check({tag, ".TimeoutB"},  bus.TimeoutB,  tb);
   endtask

   initial begin
      res        = 1'b1;
      bus.CACT   = 1'b0;
      bus.RefAck = 1'b0;
      step();
      step();
      checkAll("reset", 1'b0, 1'b0, 1'b0, 1'b0);

      // Refresh timing: expires at every multiple of 384 edges after reset release.
      res = 1'b0;
      n   = 0;
      stepTo(383);
      check("req_before_384", bus.RefReq, 1'b0);
      step();
      check("req_at_384", bus.RefReq, 1'b1);
      check("urg_at_384", bus.RefUrgent, 1'b0);
      stepTo(767);
      check("urg_before_768", bus.RefUrgent, 1'b0);
      step();
      check("urg_at_768", bus.RefUrgent, 1'b1);
      check("req_at_768", bus.RefReq, 1'b1);
      stepTo(1568);
      check("req_saturated", bus.RefReq, 1'b1);
      check("urg_saturated", bus.RefUrgent, 1'b1);

      // Mid-interval ack from URGENT.
      bus.RefAck = 1'b1;
      step();
      bus.RefAck = 1'b0;
      check("ack_mid_req", bus.RefReq, 1'b0);
      check("ack_mid_urg", bus.RefUrgent, 1'b0);

      // Ack while idle is ignored.
      stepTo(1600);
      bus.RefAck = 1'b1;
      step();
      bus.RefAck = 1'b0;
      check("ack_idle_req", bus.RefReq, 1'b0);

      // Next request lands on the original 384-clock grid.
      stepTo(1919);
      check("req_before_1920", bus.RefReq, 1'b0);
      step();
      check("req_at_1920", bus.RefReq, 1'b1);
      stepTo(2304);
      check("urg_at_2304", bus.RefUrgent, 1'b1);

      // Ack coincident with expire while URGENT.
      stepTo(2687);
      bus.RefAck = 1'b1;
      step();
      bus.RefAck = 1'b0;
      check("urg_coinc_req", bus.RefReq, 1'b1);
      check("urg_coinc_urg", bus.RefUrgent, 1'b0);

      // Ack coincident with expire while PEND.
      stepTo(3071);
      bus.RefAck = 1'b1;
      step();
      bus.RefAck = 1'b0;
      check("pend_coinc_req", bus.RefReq, 1'b1);
      check("pend_coinc_urg", bus.RefUrgent, 1'b0);
      step();
      check("pend_coinc_hold", bus.RefReq, 1'b1);

      // CACT high for 20 clocks.
      bus.CACT = 1'b1;
      repeat (15) step();
      check("to20_A_edge15", bus.TimeoutA, 1'b0);
      step();
      check("to20_A_edge16", bus.TimeoutA, 1'b1);
      check("to20_B_edge16", bus.TimeoutB, 1'b0);
      repeat (4) step();
      check("to20_A_edge20", bus.TimeoutA, 1'b1);
      check("to20_B_edge20", bus.TimeoutB, 1'b0);
      bus.CACT = 1'b0;
      step();
      check("to20_A_clear", bus.TimeoutA, 1'b0);
      check("to20_B_clear", bus.TimeoutB, 1'b0);

      // CACT high for 300 clocks.
      bus.CACT = 1'b1;
      repeat (15) step();
      check("to300_A_edge15", bus.TimeoutA, 1'b0);
      step();
      check("to300_A_edge16", bus.TimeoutA, 1'b1);
      repeat (238) step();
      check("to300_B_edge254", bus.TimeoutB, 1'b0);
      step();
      check("to300_B_edge255", bus.TimeoutB, 1'b1);
      check("to300_A_edge255", bus.TimeoutA, 1'b1);
      repeat (45) step();
      check("to300_A_edge300", bus.TimeoutA, 1'b1);
      check("to300_B_edge300", bus.TimeoutB, 1'b1);
      bus.CACT = 1'b0;
      step();
      check("to300_A_clear", bus.TimeoutA, 1'b0);
      check("to300_B_clear", bus.TimeoutB, 1'b0);

      // 200 high, one clock low, high again; then reset mid-cycle.
      bus.CACT = 1'b1;
      repeat (200) step();
      check("to200_A", bus.TimeoutA, 1'b1);
      check("to200_B", bus.TimeoutB, 1'b0);
      bus.CACT = 1'b0;
      step();
      check("gap_A_clear", bus.TimeoutA, 1'b0);
      bus.CACT = 1'b1;
      repeat (15) step();
      check("rearm_A_edge15", bus.TimeoutA, 1'b0);
      step();
      check("rearm_A_edge16", bus.TimeoutA, 1'b1);
      check("rearm_B_edge16", bus.TimeoutB, 1'b0);
      repeat (84) step();
      res = 1'b1;
      step();
      checkAll("midreset", 1'b0, 1'b0, 1'b0, 1'b0);

      // Progress before the reset is discarded.
      res      = 1'b0;
      bus.CACT = 1'b0;
      n        = 0;
      stepTo(383);
      check("post_reset_req_383", bus.RefReq, 1'b0);
      step();
      check("post_reset_req_384", bus.RefReq, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
